// File: rtl/fbcpu_boot_ctrl.sv
// Boot controller: loads a program into RAM, runs the CPU until halt or
// timeout, then streams the RAM contents back out on request.
module fbcpu_boot_ctrl #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int HALT_CYCLES   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     ld_valid,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  input  logic                     dump_req,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  input  logic                     rd_ready,
  output logic                     cpu_rst,
  input  logic [ADDRESS_WIDTH-1:0] cpu_MAR,
  input  logic                     cpu_RAMWr,
  input  logic [DATA_WIDTH-1:0]    cpu_MDRIn,
  input  logic [5:0]               cpu_PC,
  output logic [ADDRESS_WIDTH-1:0] ram_MAR,
  output logic                     ram_Wr,
  output logic [DATA_WIDTH-1:0]    ram_MDRIn,
  input  logic [DATA_WIDTH-1:0]    ram_MDROut,
  output logic                     busy,
  output logic                     halted,
  output logic                     timeout,
  output logic [15:0]              run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_DUMP_A,
    S_DUMP_D
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] MAX_ADDR = {ADDRESS_WIDTH{1'b1}};
  localparam logic [7:0] HALT_LIM = 8'(HALT_CYCLES - 1);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] ld_addr;
  logic [ADDRESS_WIDTH-1:0] dp_addr;
  logic [DATA_WIDTH-1:0]    rd_q;
  logic                     rd_fresh;
  logic [7:0]               stable;
  logic [5:0]               prev_pc;
  logic                     first_run;

  logic [7:0]  stable_nxt;
  logic [15:0] rc_nxt;
  logic        halt_hit;
  logic        tmo_hit;
  logic        ld_end;

  // The first RUN cycle has no valid previous PC, so it counts as a change.
  assign stable_nxt = (first_run || cpu_PC != prev_pc) ? 8'd0
                                                      : stable + 8'd1;
  assign halt_hit = (stable_nxt == HALT_LIM);
  assign rc_nxt = (run_cycles == 16'hFFFF) ? 16'hFFFF
                                           : run_cycles + 16'd1;
  assign tmo_hit = (rc_nxt == 16'hFFFF);
  assign ld_end = ld_valid && (ld_last || ld_addr == MAX_ADDR);

  assign ld_ready = (state == S_LOAD);
  assign rd_valid = (state == S_DUMP_D);
  assign cpu_rst  = (state != S_RUN);
  assign busy     = (state == S_LOAD) || (state == S_RUN) ||
                    (state == S_DUMP_A) || (state == S_DUMP_D);

  // RAM read data lands one cycle after the address, i.e. in the first
  // DUMP_D cycle; pass it through then and hold the captured copy after.
  assign rd_data = (state == S_DUMP_D && rd_fresh) ? ram_MDROut : rd_q;

  always_comb begin
    ram_MAR   = '0;
    ram_Wr    = 1'b0;
    ram_MDRIn = '0;
    unique case (state)
      S_LOAD: begin
        ram_MAR   = ld_addr;
        ram_Wr    = ld_valid;
        ram_MDRIn = ld_data;
      end
      S_RUN: begin
        ram_MAR   = cpu_MAR;
        ram_Wr    = cpu_RAMWr;
        ram_MDRIn = cpu_MDRIn;
      end
      S_DUMP_A, S_DUMP_D: begin
        ram_MAR = dp_addr;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ld_addr    <= '0;
      dp_addr    <= '0;
      rd_q       <= '0;
      rd_fresh   <= 1'b0;
      stable     <= '0;
      prev_pc    <= '0;
      first_run  <= 1'b0;
      run_cycles <= '0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LOAD;
            ld_addr    <= '0;
            run_cycles <= '0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_end) begin
            state     <= S_RUN;
            first_run <= 1'b1;
            stable    <= '0;
          end else if (ld_valid) begin
            ld_addr <= ld_addr + 1'b1;
          end
        end
        S_RUN: begin
          run_cycles <= rc_nxt;
          stable     <= stable_nxt;
          prev_pc    <= cpu_PC;
          first_run  <= 1'b0;
          // Halt takes priority when both end conditions coincide.
          if (halt_hit) begin
            halted <= 1'b1;
            state  <= S_DONE;
          end else if (tmo_hit) begin
            timeout <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (start) begin
            state      <= S_LOAD;
            ld_addr    <= '0;
            run_cycles <= '0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
          end else if (dump_req) begin
            state   <= S_DUMP_A;
            dp_addr <= '0;
          end
        end
        S_DUMP_A: begin
          state    <= S_DUMP_D;
          rd_fresh <= 1'b1;
        end
        S_DUMP_D: begin
          if (rd_fresh) begin
            rd_q     <= ram_MDROut;
            rd_fresh <= 1'b0;
          end
          if (rd_ready) begin
            if (dp_addr == MAX_ADDR) begin
              state <= S_DONE;
            end else begin
              dp_addr <= dp_addr + 1'b1;
              state   <= S_DUMP_A;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
